uart_tx_arbiter: RTL and testbench

Shares one UART transmitter between NUM_REQ byte sources. Each source presents bytes with a valid/ready handshake and marks the final byte of a message with a last flag. A round-robin arbiter grants the transmitter per message, not per byte, so messages never interleave on the serial line. The block sits between application byte producers and the UART transmitter's DV/Byte/Active/Done interface.

---
 rtl/uart_arb_pkg.sv | 12 +
 rtl/rr_priority_picker.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encodings and byte width for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ISSUE     = 2'b01,
        ST_WAIT_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: finds the first set request after ptr, wrapping around.
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Walk the candidates farthest-first so the nearest one after ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N; i >= 1; i--) begin
            if (req[IDX_W'((int'(ptr) + i) % N)]) begin
                found = 1'b1;
                idx   = IDX_W'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: per-message round-robin sharing of one UART transmitter among byte sources.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int GAP_TIMEOUT = 1024,
    parameter int IDX_W       = $clog2(NUM_REQ)
) (
    input  logic                      i_Clock,
    input  logic                      i_Rst,
    input  logic [NUM_REQ-1:0]        i_Req_Valid,
    input  logic [BYTE_W*NUM_REQ-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]        i_Req_Last,
    output logic [NUM_REQ-1:0]        o_Req_Ready,
    output logic                      o_TX_DV,
    output logic [BYTE_W-1:0]         o_TX_Byte,
    input  logic                      i_TX_Active,
    input  logic                      i_TX_Done,
    output logic                      o_Grant_Valid,
    output logic [IDX_W-1:0]          o_Grant_Idx,
    output logic                      o_Timeout
);

    localparam int CNT_W = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    state_t              state, state_n;
    logic [IDX_W-1:0]    owner, owner_n, ptr, ptr_n, pick_idx;
    logic [NUM_REQ-1:0]  ready_n;
    logic [BYTE_W-1:0]   byte_n;
    logic [BYTE_W-1:0]   req_byte [NUM_REQ];
    logic [CNT_W-1:0]    gap_cnt, gap_n;
    logic                pick_found, last_flag, last_n, gv_n, dv_n, tmo_n;
    logic                own_valid, xfer, gap_hit;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_byte
        assign req_byte[k] = i_Req_Byte[k*BYTE_W +: BYTE_W];
    end

    rr_priority_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (i_Req_Valid),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign own_valid   = i_Req_Valid[owner];
    assign xfer        = own_valid && o_Req_Ready[owner];
    assign gap_hit     = (GAP_TIMEOUT > 0) && !own_valid && (gap_cnt + 1'b1 == CNT_W'(GAP_TIMEOUT));
    assign o_Grant_Idx = owner;

    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        last_n  = last_flag;
        gv_n    = o_Grant_Valid;
        byte_n  = o_TX_Byte;
        ready_n = '0;
        gap_n   = '0;
        dv_n    = 1'b0;
        tmo_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_n = ST_ISSUE;
                    owner_n = pick_idx;
                    gv_n    = 1'b1;
                    ready_n = i_TX_Active ? '0 : ONE << pick_idx;
                end
            end
            ST_ISSUE: begin
                if (xfer) begin
                    state_n = ST_WAIT_DONE;
                    byte_n  = req_byte[owner];
                    last_n  = i_Req_Last[owner];
                    dv_n    = 1'b1;
                end else if (gap_hit) begin
                    state_n = ST_IDLE;
                    ptr_n   = owner;
                    owner_n = '0;
                    gv_n    = 1'b0;
                    tmo_n   = 1'b1;
                end else begin
                    gap_n   = (GAP_TIMEOUT > 0 && !own_valid) ? gap_cnt + 1'b1 : '0;
                    ready_n = (i_TX_Active || o_TX_DV) ? '0 : ONE << owner;
                end
            end
            ST_WAIT_DONE: begin
                // The owner keeps the grant across bytes; only its last byte frees the UART.
                if (i_TX_Done && last_flag) begin
                    state_n = ST_IDLE;
                    ptr_n   = owner;
                    owner_n = '0;
                    gv_n    = 1'b0;
                end else if (i_TX_Done) begin
                    state_n = ST_ISSUE;
                    ready_n = i_TX_Active ? '0 : ONE << owner;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            state         <= ST_IDLE;
            owner         <= '0;
            ptr           <= IDX_W'(NUM_REQ - 1);
            last_flag     <= 1'b0;
            gap_cnt       <= '0;
            o_Req_Ready   <= '0;
            o_TX_DV       <= 1'b0;
            o_TX_Byte     <= '0;
            o_Grant_Valid <= 1'b0;
            o_Timeout     <= 1'b0;
        end else begin
            state         <= state_n;
            owner         <= owner_n;
            ptr           <= ptr_n;
            last_flag     <= last_n;
            gap_cnt       <= gap_n;
            o_Req_Ready   <= ready_n;
            o_TX_DV       <= dv_n;
            o_TX_Byte     <= byte_n;
            o_Grant_Valid <= gv_n;
            o_Timeout     <= tmo_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench with a behavioural UART on the transmit side.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    typedef struct packed {logic last; logic [7:0] b;} src_t;
    typedef struct packed {logic [1:0] idx; logic [7:0] b;} exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_last, dut_ready, took;
    logic [8*N-1:0] req_byte;
    logic           dut_dv, tx_active, tx_done, dut_gv, dut_tmo, m_active, act_force, tx_line, prev_dv;
    logic [7:0]     dut_byte;
    logic [1:0]     dut_idx;
    logic [9:0]     frame;
    logic [9:0]     exp_line = 10'b1101001010;
    src_t           src_q [N][$];
    exp_t           sb [$];
    exp_t           e;
    int             errors = 0;
    int             checks = 0;

    always #5 clk = ~clk;
    assign tx_active = m_active | act_force;

    uart_tx_arbiter #(
        .NUM_REQ     (N),
        .GAP_TIMEOUT (8)
    ) dut (
        .i_Clock       (clk),
        .i_Rst         (rst),
        .i_Req_Valid   (req_valid),
        .i_Req_Byte    (req_byte),
        .i_Req_Last    (req_last),
        .o_Req_Ready   (dut_ready),
        .o_TX_DV       (dut_dv),
        .o_TX_Byte     (dut_byte),
        .i_TX_Active   (tx_active),
        .i_TX_Done     (tx_done),
        .o_Grant_Valid (dut_gv),
        .o_Grant_Idx   (dut_idx),
        .o_Timeout     (dut_tmo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_src(input int k, input logic last, input logic [7:0] b);
        src_q[k].push_back({last, b});
    endtask

    task automatic expect_tx(input logic [1:0] idx, input logic [7:0] b);
        sb.push_back({idx, b});
    endtask

    function automatic bit srcs_empty();
        for (int k = 0; k < N; k++) if (src_q[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // kind 0: UART done, 1: DV pulse, 2: grant to requester 3
    task automatic wait_ev(input string tag, input int kind);
        int i;
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((kind == 0 && tx_done === 1'b1) || (kind == 1 && dut_dv === 1'b1) ||
                (kind == 2 && dut_gv === 1'b1 && dut_idx === 2'd3)) break;
        end
        check(tag, 32'(i < 400), 1);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && dut_gv === 1'b0 && tx_active === 1'b0 && srcs_empty()) break;
        end
        check(tag, 32'(i < 3000), 1);
    endtask

    // Requesters: present the head of each queue, pop after a sampled valid&ready.
    initial begin
        req_valid = '0;
        req_byte  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            took = req_valid & dut_ready;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (took[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
                req_valid[k]       = src_q[k].size() != 0;
                req_byte[8*k +: 8] = (src_q[k].size() != 0) ? src_q[k][0].b : 8'h00;
                req_last[k]        = (src_q[k].size() != 0) ? src_q[k][0].last : 1'b0;
            end
        end
    end

    // UART: 4 clocks per bit, start/8 data LSB-first/stop, Done pulse after the stop bit.
    initial begin
        m_active = 1'b0;
        tx_done  = 1'b0;
        tx_line  = 1'b1;
        forever begin
            @(negedge clk);
            if (dut_dv === 1'b1) begin
                frame = {1'b1, dut_byte, 1'b0};
                @(posedge clk);
                #1;
                m_active = 1'b1;
                for (int b = 0; b < 10; b++) begin
                    tx_line = frame[b];
                    repeat (4) @(posedge clk);
                    #1;
                end
                tx_done  = 1'b1;
                m_active = 1'b0;
                tx_line  = 1'b1;
                @(posedge clk);
                #1;
                tx_done = 1'b0;
            end
        end
    end

    // Scoreboard: every DV pulse must match the next expected owner/byte.
    initial begin
        prev_dv = 1'b0;
        forever begin
            @(negedge clk);
            if (dut_dv === 1'b1) begin
                check("dv_single_cycle", 32'(prev_dv), 0);
                check("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("dv_byte", 32'(dut_byte), 32'(e.b));
                    check("dv_idx", 32'(dut_idx), 32'(e.idx));
                end
            end
            prev_dv = dut_dv;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        act_force = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dv", 32'(dut_dv), 0);
        check("rst_byte", 32'(dut_byte), 0);
        check("rst_ready", 32'(dut_ready), 0);
        check("rst_gv", 32'(dut_gv), 0);
        check("rst_idx", 32'(dut_idx), 0);
        check("rst_tmo", 32'(dut_tmo), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte: latency, serial framing, grant release after Done.
        push_src(0, 1'b1, 8'hA5);
        expect_tx(2'd0, 8'hA5);
        @(negedge clk);
        check("lat_t0_gv", 32'(dut_gv), 0);
        @(negedge clk);
        check("lat_t1_gv", 32'(dut_gv), 1);
        check("lat_t1_idx", 32'(dut_idx), 0);
        check("lat_t1_ready", 32'(dut_ready), 32'h1);
        @(negedge clk);
        check("lat_t2_dv", 32'(dut_dv), 1);
        check("lat_t2_byte", 32'(dut_byte), 32'hA5);
        @(negedge clk);
        check("lat_t3_dv", 32'(dut_dv), 0);
        check("lat_t3_ready", 32'(dut_ready), 0);
        for (int b = 0; b < 10; b++) begin
            check("serial_bit", 32'(tx_line), 32'(exp_line[b]));
            if (b < 9) repeat (4) @(negedge clk);
        end
        wait_ev("single_done", 0);
        check("single_gv_at_done", 32'(dut_gv), 1);
        @(negedge clk);
        check("single_gv_drop", 32'(dut_gv), 0);
        wait_idle("single_idle");

        // Message lock: req1's three bytes go out before req2's pending byte.
        push_src(1, 1'b0, 8'h11);
        push_src(1, 1'b0, 8'h22);
        push_src(1, 1'b1, 8'h33);
        push_src(2, 1'b1, 8'h44);
        expect_tx(2'd1, 8'h11);
        expect_tx(2'd1, 8'h22);
        expect_tx(2'd1, 8'h33);
        expect_tx(2'd2, 8'h44);
        for (int m = 0; m < 3; m++) begin
            wait_ev("lock_done", 0);
            check("lock_idx", 32'(dut_idx), 1);
            @(negedge clk);
            check("lock_gv", 32'(dut_gv), 32'(m < 2));
        end
        wait_idle("lock_idle");

        // Round robin from a fresh pointer: 0,1,2,3 three times.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N; k++) begin
                push_src(k, 1'b1, 8'(16 * k + r + 1));
                expect_tx(2'(k), 8'(16 * k + r + 1));
            end
        end
        wait_idle("rr_idle");

        // Gap timeout: req3 stalls mid-message, req0 is granted afterwards.
        push_src(3, 1'b0, 8'h01);
        expect_tx(2'd3, 8'h01);
        wait_ev("tmo_grant3", 2);
        push_src(0, 1'b1, 8'h5A);
        expect_tx(2'd0, 8'h5A);
        wait_ev("tmo_done", 0);
        repeat (8) @(negedge clk);
        check("tmo_early", 32'(dut_tmo), 0);
        @(negedge clk);
        check("tmo_pulse", 32'(dut_tmo), 1);
        check("tmo_release", 32'(dut_gv), 0);
        @(negedge clk);
        check("tmo_end", 32'(dut_tmo), 0);
        check("tmo_next_gv", 32'(dut_gv), 1);
        check("tmo_next_idx", 32'(dut_idx), 0);
        wait_idle("tmo_idle");

        // Active gating: no ready or DV while the UART reports busy.
        act_force = 1'b1;
        push_src(0, 1'b1, 8'h3C);
        expect_tx(2'd0, 8'h3C);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("gate_ready", 32'(dut_ready), 0);
            check("gate_dv", 32'(dut_dv), 0);
        end
        check("gate_gv", 32'(dut_gv), 1);
        act_force = 1'b0;
        @(negedge clk);
        check("gate_release_ready", 32'(dut_ready), 32'h1);
        @(negedge clk);
        check("gate_release_dv", 32'(dut_dv), 1);
        wait_idle("gate_idle");

        // Reset while req2 waits for Done; the stale Done must not release req0.
        push_src(2, 1'b0, 8'h77);
        push_src(2, 1'b1, 8'h78);
        expect_tx(2'd2, 8'h77);
        wait_ev("mid_dv", 1);
        push_src(0, 1'b1, 8'h99);
        expect_tx(2'd0, 8'h99);
        expect_tx(2'd2, 8'h78);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_dv", 32'(dut_dv), 0);
        check("mid_rst_byte", 32'(dut_byte), 0);
        check("mid_rst_ready", 32'(dut_ready), 0);
        check("mid_rst_gv", 32'(dut_gv), 0);
        check("mid_rst_idx", 32'(dut_idx), 0);
        check("mid_rst_tmo", 32'(dut_tmo), 0);
        rst = 1'b0;
        wait_ev("stale_done", 0);
        check("stale_gv", 32'(dut_gv), 1);
        check("stale_idx", 32'(dut_idx), 0);
        @(negedge clk);
        check("stale_gv_kept", 32'(dut_gv), 1);
        check("stale_idx_kept", 32'(dut_idx), 0);
        wait_idle("mid_idle");

        check("sb_drain", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
